sw_debounce2: RTL and testbench

- Two-channel switch conditioner for the IceZUM board.
- Sits directly upstream of the 2-input logic gate exercises.
- Takes raw, bouncing SW1/SW2 pad levels and produces clean, synchronized levels that drive the gate's SW1/SW2 inputs.
- Also produces single-cycle rise/fall pulses for later counter and FSM labs.

---
 rtl/sw_debounce2.sv | 98 +++++++++
 tb/tb_sw_debounce2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce2.sv
// Two-channel switch debouncer: 2-FF synchronizer plus a per-channel persistence counter,
// with registered one-cycle rise/fall pulses. Define SW_DEBOUNCE_INV_EN for active-low inputs.
module sw_debounce2 #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] sw_in,
  output logic [1:0] sw_out,
  output logic [1:0] sw_rise,
  output logic [1:0] sw_fall
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] raw;

`ifdef SW_DEBOUNCE_INV_EN
  // Pull-up pushbuttons idle high; invert so that sw_out=1 means "pressed".
  assign raw = ~sw_in;
`else
  assign raw = sw_in;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    state_t           state, state_nxt;
    logic             out_q, out_nxt;
    logic             rise_q, rise_nxt;
    logic             fall_q, fall_nxt;

    // NOTE: every flop here uses non-blocking assignments so all registers update
    // from the same pre-edge values; blocking would collapse s1->s2 into one stage.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        state  <= IDLE;
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s1     <= raw[i];
        s2     <= s1;
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        out_q  <= out_nxt;
        rise_q <= rise_nxt;
        fall_q <= fall_nxt;
      end
    end

    // NOTE: every output of this block gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      out_nxt   = out_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
        IDLE: begin
          if (s2 != out_q) begin
            state_nxt = COUNT;
            cnt_nxt   = CNT_W'(1);
          end
        end
        COUNT: begin
          if (s2 == out_q) begin
            state_nxt = IDLE;
          end else if (cnt == LAST) begin
            // Level held for the full window: accept it and pulse once.
            out_nxt   = s2;
            rise_nxt  = s2;
            fall_nxt  = ~s2;
          end else begin
            state_nxt = COUNT;
            cnt_nxt   = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign sw_out[i]  = out_q;
    assign sw_rise[i] = rise_q;
    assign sw_fall[i] = fall_q;
  end

endmodule

// File: tb/tb_sw_debounce2.sv
// Self-checking bench for sw_debounce2: directed scenarios plus random stimulus compared
// against a sliding-window reference model (a level is accepted once D synced samples all differ).
module tb_sw_debounce2;

  localparam int D = 8;
  localparam int W = 4;

`ifdef SW_DEBOUNCE_INV_EN
  localparam logic [1:0] INV = 2'b11;
`else
  localparam logic [1:0] INV = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] sw_in;
  logic [1:0] sw_out, sw_rise, sw_fall;

  sw_debounce2 #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: history of effective raw samples, newest at index 0.
  logic       smp [2][D+2];
  logic [1:0] m_out, m_rise, m_fall;

  int edge_idx;
  int rise_cnt [2];
  int fall_cnt [2];
  int first_rise [2];
  int first_fall [2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int j = 0; j < D + 2; j++) smp[c][j] = 1'b0;
    m_out  = 2'b00;
    m_rise = 2'b00;
    m_fall = 2'b00;
  endfunction

  // The FSM at edge n sees the raw sample of edge n-2; it flips once the D samples
  // n-2 .. n-D-1 all disagree with the current output.
  function automatic void model_edge();
    logic [1:0] eff;
    logic       flip;
    eff = sw_in ^ INV;
    for (int c = 0; c < 2; c++) begin
      for (int j = D + 1; j > 0; j--) smp[c][j] = smp[c][j-1];
      smp[c][0] = eff[c];
      flip = 1'b1;
      for (int j = 2; j < D + 2; j++)
        if (smp[c][j] == m_out[c]) flip = 1'b0;
      m_rise[c] = flip & ~m_out[c];
      m_fall[c] = flip & m_out[c];
      if (flip) m_out[c] = ~m_out[c];
    end
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [1:0] pressed);
    sw_in = pressed ^ INV;
  endtask

  task automatic clear_stats();
    edge_idx = 0;
    for (int c = 0; c < 2; c++) begin
      rise_cnt[c]   = 0;
      fall_cnt[c]   = 0;
      first_rise[c] = -1;
      first_fall[c] = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_edge();
    edge_idx++;
    @(negedge clk);
    chk("model_out",  sw_out,  m_out);
    chk("model_rise", sw_rise, m_rise);
    chk("model_fall", sw_fall, m_fall);
    chk("rise_fall_excl", sw_rise & sw_fall, 2'b00);
    for (int c = 0; c < 2; c++) begin
      if (sw_rise[c]) begin
        rise_cnt[c]++;
        if (first_rise[c] < 0) first_rise[c] = edge_idx;
      end
      if (sw_fall[c]) begin
        fall_cnt[c]++;
        if (first_fall[c] < 0) first_fall[c] = edge_idx;
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic lvl;

    // Reset with both switches pressed.
    rstn = 1'b0;
    drv(2'b11);
    model_reset();
    clear_stats();
    ticks(3);
    chk("rst_out", sw_out, 2'b00);
    chk("rst_pulses", sw_rise | sw_fall, 2'b00);
    rstn = 1'b1;
    clear_stats();
    ticks(20);
    chk_int("rel_rise_edge0", first_rise[0], 10);
    chk_int("rel_rise_edge1", first_rise[1], 10);
    chk_int("rel_rise_cnt0", rise_cnt[0], 1);
    chk_int("rel_rise_cnt1", rise_cnt[1], 1);
    chk_int("rel_fall_cnt", fall_cnt[0] + fall_cnt[1], 0);
    chk("rel_out", sw_out, 2'b11);

    // Clean press and release on channel 0.
    drv(2'b00);
    ticks(20);
    chk("idle_out", sw_out, 2'b00);
    clear_stats();
    drv(2'b01);
    ticks(20);
    chk_int("press_rise_edge", first_rise[0], 10);
    chk_int("press_rise_cnt", rise_cnt[0], 1);
    chk_int("press_ch1_quiet", rise_cnt[1] + fall_cnt[1], 0);
    chk("press_out", sw_out, 2'b01);
    clear_stats();
    drv(2'b00);
    ticks(20);
    chk_int("release_fall_edge", first_fall[0], 10);
    chk_int("release_fall_cnt", fall_cnt[0], 1);
    chk_int("release_ch1_quiet", rise_cnt[1] + fall_cnt[1], 0);
    chk("release_out", sw_out, 2'b00);

    // Bounce on channel 1: toggle every 3 cycles, then hold high.
    clear_stats();
    lvl = 1'b0;
    repeat (8) begin
      lvl = ~lvl;
      drv({lvl, 1'b0});
      ticks(3);
    end
    chk_int("bounce_quiet", rise_cnt[1] + fall_cnt[1], 0);
    chk("bounce_out", sw_out, 2'b00);
    clear_stats();
    drv(2'b10);
    ticks(20);
    chk_int("bounce_rise_edge", first_rise[1], 10);
    chk_int("bounce_rise_cnt", rise_cnt[1], 1);
    chk("bounce_settled", sw_out, 2'b10);

    // Glitch one cycle shorter than the window on channel 0.
    clear_stats();
    drv(2'b11);
    ticks(D - 1);
    drv(2'b10);
    ticks(15);
    chk_int("glitch_quiet", rise_cnt[0] + fall_cnt[0], 0);
    chk("glitch_out", sw_out, 2'b10);

    // Reset part way through the window (cnt=5), with channel 1 already high.
    clear_stats();
    drv(2'b11);
    ticks(7);
    chk("pre_rst_out", sw_out, 2'b10);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_out", sw_out, 2'b00);
    ticks(2);
    rstn = 1'b1;
    clear_stats();
    ticks(20);
    chk_int("midrst_rise_edge0", first_rise[0], 10);
    chk_int("midrst_rise_edge1", first_rise[1], 10);
    chk_int("midrst_rise_cnt0", rise_cnt[0], 1);
    chk("midrst_out", sw_out, 2'b11);

`ifdef SW_DEBOUNCE_INV_EN
    // Raw idle-high buttons give no pulse after reset; pulling SW2 low presses it.
    rstn  = 1'b0;
    sw_in = 2'b11;
    #1;
    model_reset();
    ticks(1);
    rstn = 1'b1;
    clear_stats();
    ticks(20);
    chk_int("inv_idle_quiet", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1], 0);
    chk("inv_idle_out", sw_out, 2'b00);
    clear_stats();
    sw_in = 2'b01;
    ticks(20);
    chk_int("inv_press_edge", first_rise[1], 10);
    chk_int("inv_press_cnt", rise_cnt[1], 1);
    chk("inv_press_out", sw_out, 2'b10);
`endif

    // Random levels and hold times, with occasional asynchronous resets.
    repeat (80) begin
      if ($urandom_range(0, 19) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rand_async_rst", sw_out, 2'b00);
        ticks(1);
        rstn = 1'b1;
      end else begin
        drv(2'($urandom_range(0, 3)));
        ticks($urandom_range(1, 14));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
